// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the shared Memory unit.
// Port 0 is read-only fetch, port 1 is load/store; one transfer is in flight at a time.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req_i,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    output logic [DATA_WIDTH-1:0] p0_rdata_o,
    output logic                  p0_ack_o,
    output logic                  p0_err_o,
    input  logic                  p1_req_i,
    input  logic                  p1_we_i,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    input  logic [DATA_WIDTH-1:0] p1_wdata_i,
    output logic [DATA_WIDTH-1:0] p1_rdata_o,
    output logic                  p1_ack_o,
    output logic                  p1_err_o,
    output logic                  mem_rd_en_o,
    output logic                  mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    logic [1:0]            state;
    logic                  last_grant;
    logic                  port;
    logic                  we;
    logic                  err;
    logic [7:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] p0_rdata;
    logic [DATA_WIDTH-1:0] p1_rdata;

    logic                  any_req;
    logic                  grant;
    logic [ADDR_WIDTH-1:0] grant_addr;

    // On a tie the port not served last wins; otherwise the sole requester.
    always_comb begin
        any_req    = p0_req_i | p1_req_i;
        grant      = (p0_req_i && p1_req_i) ? ~last_grant : p1_req_i;
        grant_addr = grant ? p1_addr_i : p0_addr_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            port       <= 1'b0;
            we         <= 1'b0;
            err        <= 1'b0;
            cnt        <= '0;
            addr       <= '0;
            wdata      <= '0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        port       <= grant;
                        last_grant <= grant;
                        we         <= grant & p1_we_i;
                        addr       <= grant_addr;
                        wdata      <= grant ? p1_wdata_i : '0;
                        if (grant_addr[1:0] != 2'b00) begin
                            err   <= 1'b1;
                            state <= RESP;
                        end else begin
                            err   <= 1'b0;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (mem_ack_i) begin
                        if (!we) begin
                            if (port) p1_rdata <= mem_rdata_i;
                            else      p0_rdata <= mem_rdata_i;
                        end
                        err   <= 1'b0;
                        state <= RESP;
                    end else if (cnt == TIMEOUT_CNT) begin
                        err   <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_rd_en_o = (state == ISSUE) && !we;
        mem_wr_en_o = (state == ISSUE) && we;
        mem_addr_o  = addr;
        mem_wdata_o = wdata;
        p0_ack_o    = (state == RESP) && !port;
        p1_ack_o    = (state == RESP) && port;
        p0_err_o    = (state == RESP) && !port && err;
        p1_err_o    = (state == RESP) && port && err;
        p0_rdata_o  = p0_rdata;
        p1_rdata_o  = p1_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected completions, a monitor pops them on each ack.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_req_i;
    logic [31:0] p0_addr_i;
    logic [31:0] p0_rdata_o;
    logic        p0_ack_o;
    logic        p0_err_o;
    logic        p1_req_i;
    logic        p1_we_i;
    logic [31:0] p1_addr_i;
    logic [31:0] p1_wdata_i;
    logic [31:0] p1_rdata_o;
    logic        p1_ack_o;
    logic        p1_err_o;
    logic        mem_rd_en_o;
    logic        mem_wr_en_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .p0_req_i(p0_req_i), .p0_addr_i(p0_addr_i), .p0_rdata_o(p0_rdata_o),
        .p0_ack_o(p0_ack_o), .p0_err_o(p0_err_o),
        .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i),
        .p1_wdata_i(p1_wdata_i), .p1_rdata_o(p1_rdata_o),
        .p1_ack_o(p1_ack_o), .p1_err_o(p1_err_o),
        .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] mem [logic [31:0]];
    logic        hold_ack = 1'b0;
    int          late_req = 0;
    int          late_sent = 0;
    int          rd_count = 0;
    int          wr_count = 0;
    logic [31:0] last_mem_addr = '0;
    logic [31:0] last_mem_wdata = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: latches the access on the ISSUE cycle, acks one cycle later unless held.
    initial begin
        logic        pending;
        logic [31:0] pend_data;
        pending     = 1'b0;
        pend_data   = '0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            mem_ack_i = 1'b0;
            if (mem_rd_en_o && mem_wr_en_o) begin
                errors++;
                $display("FAIL dual_enable: got rd=1 wr=1 expected at most one");
            end
            if (pending) begin
                if (!hold_ack) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = pend_data;
                end
                pending = 1'b0;
            end else if (late_sent != late_req) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = 32'hBAD0BAD0;
                late_sent++;
            end
            if (mem_rd_en_o || mem_wr_en_o) begin
                last_mem_addr  = mem_addr_o;
                last_mem_wdata = mem_wdata_o;
                if (mem_wr_en_o) begin
                    wr_count++;
                    mem[mem_addr_o] = mem_wdata_o;
                end else begin
                    rd_count++;
                    pend_data = mem.exists(mem_addr_o) ? mem[mem_addr_o] : 32'h0;
                end
                pending = 1'b1;
            end
        end
    end

    // Monitor: every ack pulse must match the oldest expected completion.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (p0_ack_o || p1_ack_o) begin
                if (p0_ack_o && p1_ack_o) begin
                    checks++;
                    errors++;
                    $display("FAIL dual_ack: got p0_ack=1 p1_ack=1 expected one");
                end else if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got p0_ack=%0d p1_ack=%0d expected none at cycle %0d",
                             p0_ack_o, p1_ack_o, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("ack_port", {31'b0, p1_ack_o}, 32'(e.port));
                    chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                    chk("ack_err", {31'b0, p1_ack_o ? p1_err_o : p0_err_o}, {31'b0, e.err});
                    chk("other_err", {31'b0, p1_ack_o ? p0_err_o : p1_err_o}, 32'h0);
                    chk("p0_rdata", p0_rdata_o, e.rd0);
                    chk("p1_rdata", p1_rdata_o, e.rd1);
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {26'b0, p0_ack_o, p0_err_o, p1_ack_o, p1_err_o, mem_rd_en_o, mem_wr_en_o}, 32'h0);
        chk({tag, "_p0_rdata"}, p0_rdata_o, 32'h0);
        chk({tag, "_p1_rdata"}, p1_rdata_o, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr_o, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
    endtask

    task automatic do_txn(input int port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat, input logic err,
                          input logic [31:0] rd0, input logic [31:0] rd1);
        exp_t e;
        logic seen;
        @(posedge clk);
        #1;
        e.port = port; e.err = err; e.rd0 = rd0; e.rd1 = rd1; e.cyc = cyc + lat;
        sb.push_back(e);
        if (port == 0) begin
            p0_req_i  = 1'b1;
            p0_addr_i = addr;
        end else begin
            p1_req_i   = 1'b1;
            p1_we_i    = we;
            p1_addr_i  = addr;
            p1_wdata_i = wdata;
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = (port == 0) ? p0_ack_o : p1_ack_o;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ack_wait: got no ack on port %0d expected one within 40 cycles", port);
        end
        @(posedge clk);
        #1;
        p0_req_i = 1'b0;
        p1_req_i = 1'b0;
    endtask

    initial begin
        int   c;
        int   rd0_before;
        int   wr0_before;
        exp_t e;
        mem[32'h10] = 32'hDEADBEEF;
        rst = 1'b1;
        p0_req_i = 1'b0; p0_addr_i = '0;
        p1_req_i = 1'b0; p1_we_i = 1'b0; p1_addr_i = '0; p1_wdata_i = '0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single fetch
        rd0_before = rd_count; wr0_before = wr_count;
        do_txn(0, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF, 32'h0);
        chk("fetch_rd_pulses", 32'(rd_count - rd0_before), 32'd1);
        chk("fetch_wr_pulses", 32'(wr_count - wr0_before), 32'd0);
        chk("fetch_addr", last_mem_addr, 32'h10);

        // Store then load on port 1
        rd0_before = rd_count; wr0_before = wr_count;
        do_txn(1, 1'b1, 32'h40, 32'h12345678, 3, 1'b0, 32'hDEADBEEF, 32'h0);
        chk("store_wr_pulses", 32'(wr_count - wr0_before), 32'd1);
        chk("store_rd_pulses", 32'(rd_count - rd0_before), 32'd0);
        chk("store_wdata", last_mem_wdata, 32'h12345678);
        chk("store_addr", last_mem_addr, 32'h40);
        do_txn(1, 1'b0, 32'h40, 32'h0, 3, 1'b0, 32'hDEADBEEF, 32'h12345678);

        // Contention after a fresh reset: grants 0,1,0,1, four cycles apart
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        c = cyc;
        e.port = 0; e.err = 1'b0; e.rd0 = 32'hDEADBEEF; e.rd1 = 32'h0;       e.cyc = c + 3;  sb.push_back(e);
        e.port = 1; e.err = 1'b0; e.rd0 = 32'hDEADBEEF; e.rd1 = 32'h12345678; e.cyc = c + 7;  sb.push_back(e);
        e.port = 0; e.err = 1'b0; e.rd0 = 32'hDEADBEEF; e.rd1 = 32'h12345678; e.cyc = c + 11; sb.push_back(e);
        e.port = 1; e.err = 1'b0; e.rd0 = 32'hDEADBEEF; e.rd1 = 32'h12345678; e.cyc = c + 15; sb.push_back(e);
        p0_req_i = 1'b1; p0_addr_i = 32'h10;
        p1_req_i = 1'b1; p1_we_i = 1'b0; p1_addr_i = 32'h40; p1_wdata_i = '0;
        repeat (16) @(posedge clk);
        #1;
        p0_req_i = 1'b0;
        p1_req_i = 1'b0;
        chk("contention_drained", 32'(sb.size()), 32'd0);

        // Misaligned store: error one cycle after request, no memory access
        rd0_before = rd_count; wr0_before = wr_count;
        do_txn(1, 1'b1, 32'h42, 32'hCAFEF00D, 1, 1'b1, 32'hDEADBEEF, 32'h12345678);
        chk("misaligned_no_access", 32'((rd_count - rd0_before) + (wr_count - wr0_before)), 32'd0);

        // Timeout on a fetch, then a late ack that must be ignored
        hold_ack = 1'b1;
        do_txn(0, 1'b0, 32'h14, 32'h0, 19, 1'b1, 32'hDEADBEEF, 32'h12345678);
        hold_ack = 1'b0;
        late_req++;
        repeat (4) @(posedge clk);
        do_txn(1, 1'b0, 32'h40, 32'h0, 3, 1'b0, 32'hDEADBEEF, 32'h12345678);

        // Reset during WAIT: abandon silently, then a normal fetch
        hold_ack = 1'b1;
        @(posedge clk); #1;
        p0_req_i = 1'b1; p0_addr_i = 32'h10;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_all_zero("midwait_reset");
        p0_req_i = 1'b0;
        hold_ack = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        do_txn(0, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF, 32'h0);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
